// File: rtl/fp8_mac_sequencer.sv
// Command sequencer for the shared FP8 multiply-accumulate datapath.
// Clears the accumulator, streams N operand pairs, waits out the pipe, returns the sum.
module fp8_mac_sequencer #(
    parameter int LEN_W    = 8,
    parameter int PIPE_LAT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [7:0]       op_a,
    input  logic [7:0]       op_b,
    output logic [7:0]       dp_a,
    output logic [7:0]       dp_b,
    output logic             dp_issue,
    output logic             dp_acc_clr,
    input  logic [7:0]       dp_acc,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       res_data,
    output logic             busy
);

    localparam int DW = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [7:0]       dp_a_q, dp_a_d;
    logic [7:0]       dp_b_q, dp_b_d;
    logic             issue_q, issue_d;
    logic [7:0]       res_q, res_d;

    // NOTE: every _d gets its hold value first, so no branch can leave a latch behind.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        drain_d     = drain_q;
        dp_a_d      = dp_a_q;
        dp_b_d      = dp_b_q;
        issue_d     = 1'b0;
        res_d       = res_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    remaining_d = cmd_len;
                    state_d     = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (remaining_q == '0) begin
                    drain_d = DW'(PIPE_LAT);
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (op_valid && (remaining_q != '0)) begin
                    dp_a_d      = op_a;
                    dp_b_d      = op_b;
                    issue_d     = 1'b1;
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        drain_d = DW'(PIPE_LAT);
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // The last product reaches dp_acc in the cycle the count hits zero.
                if (drain_q == '0) begin
                    res_d   = dp_acc;
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use <= so every flop samples the pre-edge values together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            drain_q     <= '0;
            dp_a_q      <= 8'h00;
            dp_b_q      <= 8'h00;
            issue_q     <= 1'b0;
            res_q       <= 8'h00;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            drain_q     <= drain_d;
            dp_a_q      <= dp_a_d;
            dp_b_q      <= dp_b_d;
            issue_q     <= issue_d;
            res_q       <= res_d;
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign op_ready   = (state_q == S_STREAM) && (remaining_q != '0);
    assign dp_acc_clr = (state_q == S_CLEAR);
    assign res_valid  = (state_q == S_DONE);
    assign dp_issue   = issue_q;
    assign dp_a       = dp_a_q;
    assign dp_b       = dp_b_q;
    assign res_data   = res_q;

endmodule

// File: tb/tb_fp8_mac_sequencer.sv
// Bench for fp8_mac_sequencer: emulated datapath, timeline model checked every cycle,
// and directed scenarios with hand-computed literal expectations.
module tb_fp8_mac_sequencer;

    localparam int LEN_W = 8;
    localparam int PL    = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             op_valid = 1'b0;
    logic             op_ready;
    logic [7:0]       op_a = 8'h00;
    logic [7:0]       op_b = 8'h00;
    logic [7:0]       dp_a, dp_b;
    logic             dp_issue, dp_acc_clr;
    logic [7:0]       dp_acc;
    logic             res_valid;
    logic             res_ready = 1'b1;
    logic [7:0]       res_data;
    logic             busy;

    fp8_mac_sequencer #(.LEN_W(LEN_W), .PIPE_LAT(PL)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .dp_a(dp_a), .dp_b(dp_b), .dp_issue(dp_issue), .dp_acc_clr(dp_acc_clr),
        .dp_acc(dp_acc),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Emulated datapath: product of an issue lands on dp_acc PL cycles later;
    // "product" is a ^ b and accumulation is mod-256 add. Reset does not touch it.
    logic       s1_v = 1'b0, s2_v = 1'b0;
    logic [7:0] s1_a = 8'h00, s1_b = 8'h00, s2_a = 8'h00, s2_b = 8'h00;
    logic [7:0] acc = 8'hA5;
    always @(posedge clk) begin
        s1_v <= dp_issue; s1_a <= dp_a; s1_b <= dp_b;
        s2_v <= s1_v;     s2_a <= s1_a; s2_b <= s1_b;
        if (dp_acc_clr)  acc <= 8'h00;
        else if (s2_v)   acc <= acc + (s2_a ^ s2_b);
    end
    assign dp_acc = acc;

    // Timeline model: expectations derived from handshake times and the documented latencies.
    bit         started = 1'b0;
    bit         m_idle = 1'b1;
    int         m_cmd = -10;
    int         m_rem = 0;
    int         m_due = -1;
    bit         m_issue = 1'b0;
    logic [7:0] m_a = 8'h00, m_b = 8'h00, m_gold = 8'h00, m_res = 8'h00;
    bit         e_cr, e_or, e_clr, e_rv;
    int         issue_cycles[$];
    int         clr_cycles[$];

    always @(negedge clk) begin
        e_cr  = m_idle;
        e_clr = !m_idle && (cyc == m_cmd + 1);
        e_or  = !m_idle && (cyc >= m_cmd + 2) && (m_rem > 0);
        e_rv  = (m_due >= 0) && (cyc >= m_due);
        if (started) begin
            check("cmd_ready",  cmd_ready,  e_cr);
            check("busy",       busy,       !e_cr);
            check("dp_acc_clr", dp_acc_clr, e_clr);
            check("op_ready",   op_ready,   e_or);
            check("dp_issue",   dp_issue,   m_issue);
            check("dp_a",       dp_a,       m_a);
            check("dp_b",       dp_b,       m_b);
            check("res_valid",  res_valid,  e_rv);
            check("res_data",   res_data,   m_res);
            if (dp_issue)   issue_cycles.push_back(cyc);
            if (dp_acc_clr) clr_cycles.push_back(cyc);
        end
        if (rst) begin
            started = 1'b1;
            m_idle  = 1'b1; m_cmd = -10; m_rem = 0; m_due = -1; m_issue = 1'b0;
            m_a = 8'h00; m_b = 8'h00; m_res = 8'h00;
        end else if (started) begin
            if (e_cr && cmd_valid) begin
                m_idle = 1'b0; m_cmd = cyc; m_rem = int'(cmd_len); m_gold = 8'h00;
                m_due  = (cmd_len == 0) ? cyc + 3 + PL : -1;
            end
            m_issue = e_or && op_valid;
            if (m_issue) begin
                m_a = op_a; m_b = op_b; m_gold = m_gold + (op_a ^ op_b);
                m_rem--;
                if (m_rem == 0) m_due = cyc + 2 + PL;
            end
            if (cyc == m_due - 1) m_res = m_gold;
            if (e_rv && res_ready) begin
                m_idle = 1'b1; m_due = -1;
            end
        end
    end

    logic [7:0] a_arr[256];
    logic [7:0] b_arr[256];
    bit         pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns the acceptance cycle; leaves the bench in the cycle after CLEAR.
    task automatic send_cmd(input int len, output int c0);
        int k = 0;
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(len);
        while (!cmd_ready && k < 50) begin
            tick();
            k++;
        end
        check("cmd_accept", cmd_ready, 1);
        c0 = cyc;
        tick();
        cmd_valid = 1'b0;
        tick();
    endtask

    task automatic feed(input int n, input bit use_pat);
        int sent = 0;
        int k = 0;
        while (sent < n && k < 2000) begin
            op_valid = use_pat ? ((k < 7) ? pat[k] : 1'b0) : 1'b1;
            op_a     = a_arr[sent];
            op_b     = b_arr[sent];
            if (op_valid && op_ready) sent++;
            tick();
            k++;
        end
        op_valid = 1'b0;
        check("feed_count", sent, n);
    endtask

    task automatic wait_res(output int rcyc);
        int k = 0;
        while (!res_valid && k < 600) begin
            tick();
            k++;
        end
        check("res_timeout", res_valid, 1);
        rcyc = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0, c1, rc, ib, ic, bad;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy",      busy,      0);
        check("rst_res_data",  res_data,  8'h00);
        check("rst_dp_a",      dp_a,      8'h00);
        check("rst_dp_issue",  dp_issue,  0);

        // Reset mid-STREAM aborts, then a one-pair command completes.
        for (int i = 0; i < 5; i++) begin a_arr[i] = 8'h10 + 8'(i); b_arr[i] = 8'h03; end
        send_cmd(5, c0);
        op_valid = 1'b1; op_a = 8'h12; op_b = 8'h34;
        repeat (2) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0; op_valid = 1'b0;
        check("abort_cmd_ready", cmd_ready, 1);
        check("abort_busy",      busy,      0);
        check("abort_res_valid", res_valid, 0);
        check("abort_dp_issue",  dp_issue,  0);
        repeat (4) tick();
        a_arr[0] = 8'h7F; b_arr[0] = 8'h01;
        send_cmd(1, c0);
        feed(1, 1'b0);
        wait_res(rc);
        check("len1_res_data", res_data, 8'h7E);
        tick();

        // Two pairs back to back.
        a_arr[0] = 8'h38; b_arr[0] = 8'h40; a_arr[1] = 8'h30; b_arr[1] = 8'h38;
        ib = issue_cycles.size();
        send_cmd(2, c0);
        feed(2, 1'b0);
        wait_res(rc);
        check("len2_clr_cycle",  clr_cycles[clr_cycles.size()-1], c0 + 1);
        check("len2_issue0",     issue_cycles[ib],     c0 + 3);
        check("len2_issue1",     issue_cycles[ib + 1], c0 + 4);
        check("len2_res_cycle",  rc, c0 + 8);
        check("len2_res_data",   res_data, 8'h80);
        tick();

        // Four pairs with op_valid toggling.
        for (int i = 0; i < 4; i++) begin a_arr[i] = 8'h41 + 8'(i); b_arr[i] = 8'h0F; end
        ib = issue_cycles.size();
        send_cmd(4, c0);
        feed(4, 1'b1);
        check("len4_op_ready_drop", op_ready, 0);
        wait_res(rc);
        check("len4_issue_count", issue_cycles.size() - ib, 4);
        check("len4_issue0", issue_cycles[ib],     c0 + 3);
        check("len4_issue1", issue_cycles[ib + 1], c0 + 6);
        check("len4_issue2", issue_cycles[ib + 2], c0 + 7);
        check("len4_issue3", issue_cycles[ib + 3], c0 + 9);
        tick();

        // Zero-length command reports the cleared accumulator.
        ib = issue_cycles.size();
        send_cmd(0, c0);
        wait_res(rc);
        check("len0_clr_cycle",   clr_cycles[clr_cycles.size()-1], c0 + 1);
        check("len0_no_issue",    issue_cycles.size(), ib);
        check("len0_res_cycle",   rc, c0 + 6);
        check("len0_res_data",    res_data, 8'h00);
        tick();

        // Result backpressure with a second command waiting.
        res_ready = 1'b0;
        a_arr[0] = 8'h11; b_arr[0] = 8'h22;
        send_cmd(1, c0);
        feed(1, 1'b0);
        wait_res(rc);
        cmd_valid = 1'b1; cmd_len = 8'd3;
        for (int i = 0; i < 5; i++) begin
            check("bp_res_valid", res_valid, 1);
            check("bp_res_data",  res_data,  8'h33);
            check("bp_cmd_ready", cmd_ready, 0);
            tick();
        end
        res_ready = 1'b1;
        check("bp_release_valid", res_valid, 1);
        tick();
        check("bp_idle_cmd_ready", cmd_ready, 1);
        check("bp_idle_busy",      busy,      0);
        c1 = cyc;
        tick();
        cmd_valid = 1'b0;
        check("bp_second_clear", dp_acc_clr, 1);
        tick();
        for (int i = 0; i < 3; i++) begin a_arr[i] = 8'h01 << i; b_arr[i] = 8'h00; end
        feed(3, 1'b0);
        wait_res(rc);
        check("bp_second_res_cycle", rc, c1 + 2 + 2 + 2 + PL);
        check("bp_second_res_data",  res_data, 8'h07);
        tick();

        // Full-length stream, one pair per cycle.
        for (int i = 0; i < 255; i++) begin a_arr[i] = 8'(i); b_arr[i] = 8'h00; end
        ib = issue_cycles.size();
        send_cmd(255, c0);
        feed(255, 1'b0);
        check("max_op_ready_drop", op_ready, 0);
        wait_res(rc);
        ic = issue_cycles.size() - ib;
        check("max_issue_count", ic, 255);
        bad = 0;
        for (int i = 0; i < ic; i++) if (issue_cycles[ib + i] != c0 + 3 + i) bad++;
        check("max_issue_consecutive", bad, 0);
        check("max_res_cycle", rc, c0 + 261);
        check("max_res_data",  res_data, 8'h81);
        tick();
        repeat (4) begin
            check("max_single_result", res_valid, 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
